// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared state and target encodings for the memory loader
package mem_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_RD,
    S_CMP,
    S_START,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic SEL_DRAM = 1'b0;
  localparam logic SEL_IRAM = 1'b1;

endpackage

// File: rtl/loader_addr_ctr.sv
// rtl/loader_addr_ctr.sv - per-target write address counter with overflow flag
module loader_addr_ctr #(
  parameter int AW        = 9,
  parameter int BASE_ADDR = 1,
  parameter int MAX_ADDR  = 511
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        inc,
  output logic [AW:0] count,
  output logic        ovf
);

  // One extra bit so an address past MAX_ADDR is still representable
  localparam logic [AW:0] BASE_V = (AW+1)'(BASE_ADDR);
  localparam logic [AW:0] MAX_V  = (AW+1)'(MAX_ADDR);
  localparam logic [AW:0] ONE_V  = (AW+1)'(1);

  // Counter restarts at BASE_ADDR per session and steps after each committed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= BASE_V;
    end else if (load) begin
      count <= BASE_V;
    end else if (inc) begin
      count <= count + ONE_V;
    end
  end

  assign ovf = (count > MAX_V);

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - stream-to-DRAM/IRAM loader with fixed write timing, verify and start pulse
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 9,
  parameter int BASE_ADDR = 1,
  parameter int MAX_ADDR  = 511,
  parameter int VERIFY    = 1,
  parameter int RD_LAT    = 1,
  parameter int START_LEN = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sel,
  input  logic          s_last,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          dram_we,
  output logic          iram_we,
  output logic          dram_re,
  output logic          iram_re,
  input  logic [DW-1:0] dram_rdata,
  input  logic [DW-1:0] iram_rdata,
  output logic          proc_start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_addr,
  output logic [AW:0]   word_count
);

  state_t        state, next_state;
  logic          sel_q, last_q;
  logic [2:0]    rd_cnt;
  logic [7:0]    st_cnt;
  logic [AW:0]   d_cnt, i_cnt;
  logic          d_ovf, i_ovf;
  logic          session_start, take, ovf_hit, cmp_fail, advance;
  logic [DW-1:0] rdata_sel;

  loader_addr_ctr #(.AW(AW), .BASE_ADDR(BASE_ADDR), .MAX_ADDR(MAX_ADDR)) u_dram_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (session_start),
    .inc   (advance && (sel_q == SEL_DRAM)),
    .count (d_cnt),
    .ovf   (d_ovf)
  );

  loader_addr_ctr #(.AW(AW), .BASE_ADDR(BASE_ADDR), .MAX_ADDR(MAX_ADDR)) u_iram_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (session_start),
    .inc   (advance && (sel_q == SEL_IRAM)),
    .count (i_cnt),
    .ovf   (i_ovf)
  );

  assign rdata_sel = (sel_q == SEL_IRAM) ? iram_rdata : dram_rdata;

  // State register; reset drops straight to IDLE so enables fall asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state, enables and datapath strobes, all decoded from the current state
  always_comb begin
    next_state    = state;
    s_ready       = 1'b0;
    busy          = 1'b0;
    proc_start    = 1'b0;
    dram_we       = 1'b0;
    iram_we       = 1'b0;
    dram_re       = 1'b0;
    iram_re       = 1'b0;
    session_start = 1'b0;
    take          = 1'b0;
    ovf_hit       = 1'b0;
    cmp_fail      = 1'b0;
    advance       = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req) begin
          session_start = 1'b1;
          next_state    = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if ((s_sel == SEL_IRAM) ? i_ovf : d_ovf) begin
            ovf_hit    = 1'b1;
            next_state = S_ERR;
          end else begin
            take       = 1'b1;
            next_state = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        busy       = 1'b1;
        next_state = S_WRITE;
      end
      S_WRITE: begin
        busy       = 1'b1;
        dram_we    = (sel_q == SEL_DRAM);
        iram_we    = (sel_q == SEL_IRAM);
        next_state = S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (VERIFY != 0) begin
          next_state = S_RD;
        end else begin
          advance    = 1'b1;
          next_state = last_q ? S_START : S_ACCEPT;
        end
      end
      S_RD: begin
        busy = 1'b1;
        if (rd_cnt == 3'd0) begin
          dram_re = (sel_q == SEL_DRAM);
          iram_re = (sel_q == SEL_IRAM);
        end
        if (rd_cnt == 3'(RD_LAT - 1)) next_state = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (rdata_sel != mem_wdata) begin
          cmp_fail   = 1'b1;
          next_state = S_ERR;
        end else begin
          advance    = 1'b1;
          next_state = last_q ? S_START : S_ACCEPT;
        end
      end
      S_START: begin
        busy       = 1'b1;
        proc_start = 1'b1;
        if (st_cnt == 8'(START_LEN - 1)) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latched word, address, sticky status and per-state cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= SEL_DRAM;
      last_q     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_addr   <= '0;
      word_count <= '0;
      rd_cnt     <= '0;
      st_cnt     <= '0;
    end else begin
      if (session_start) begin
        done       <= 1'b0;
        error      <= 1'b0;
        err_addr   <= '0;
        word_count <= '0;
      end
      if (take) begin
        sel_q     <= s_sel;
        last_q    <= s_last;
        mem_wdata <= s_data;
        mem_addr  <= (s_sel == SEL_IRAM) ? i_cnt[AW-1:0] : d_cnt[AW-1:0];
      end
      if (ovf_hit) begin
        error    <= 1'b1;
        err_addr <= (s_sel == SEL_IRAM) ? i_cnt[AW-1:0] : d_cnt[AW-1:0];
      end
      if (cmp_fail) begin
        error    <= 1'b1;
        err_addr <= mem_addr;
      end
      if (advance) word_count <= word_count + (AW+1)'(1);
      if (state == S_START && next_state == S_DONE) done <= 1'b1;
      rd_cnt <= (state == S_RD)    ? rd_cnt + 3'd1 : 3'd0;
      st_cnt <= (state == S_START) ? st_cnt + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk, rst_n, load_req, s_valid, s_ready, s_sel, s_last;
  logic [DW-1:0] s_data, mem_wdata, dram_rdata, iram_rdata;
  logic [AW-1:0] mem_addr, err_addr;
  logic          dram_we, iram_we, dram_re, iram_re, proc_start, busy, done, error;
  logic [AW:0]   word_count;

  mem_loader #(.DW(DW), .AW(AW), .BASE_ADDR(1), .MAX_ADDR(3), .VERIFY(1), .RD_LAT(1), .START_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sel      (s_sel),
    .s_last     (s_last),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .dram_we    (dram_we),
    .iram_we    (iram_we),
    .dram_re    (dram_re),
    .iram_re    (iram_re),
    .dram_rdata (dram_rdata),
    .iram_rdata (iram_rdata),
    .proc_start (proc_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_addr   (err_addr),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] dram_mem [0:511];
  logic [DW-1:0] iram_mem [0:511];
  logic          corrupt;

  always @(posedge clk) begin
    if (dram_we) dram_mem[mem_addr] <= mem_wdata;
    if (iram_we) iram_mem[mem_addr] <= mem_wdata;
    if (dram_re) dram_rdata <= dram_mem[mem_addr] ^ ((corrupt && mem_addr == 9'd2) ? 16'h0001 : 16'h0000);
    if (iram_re) iram_rdata <= iram_mem[mem_addr];
  end

  int n_ps, n_ovl, n_dwe;
  initial begin
    n_ps = 0; n_ovl = 0; n_dwe = 0;
  end
  always @(negedge clk) begin
    n_ps  <= n_ps + int'(proc_start);
    n_dwe <= n_dwe + int'(dram_we);
    if ((int'(dram_we) + int'(iram_we) + int'(dram_re) + int'(iram_re)) > 1) n_ovl <= n_ovl + 1;
  end

  int n_pass, n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send(input logic sel, input logic [DW-1:0] d, input logic last);
    int k;
    s_sel = sel; s_data = d; s_last = last; s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) begin
      n_total++;
      $display("FAIL accept_timeout: got s_ready=0 expected 1 within 40 cycles");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || error) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!(done || error)) begin
      n_total++;
      $display("FAIL end_timeout: got done=0 error=0 expected one of them within 300 cycles");
    end
  endtask

  typedef struct {
    int            sess;
    logic          sel;
    logic [DW-1:0] data;
    logic          last;
    int            exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic run_session(input int s, input int exp_wc);
    int ps0;
    logic [DW-1:0] got;
    ps0 = n_ps;
    pulse_load();
    for (int i = 0; i < 10; i++)
      if (vecs[i].sess == s) send(vecs[i].sel, vecs[i].data, vecs[i].last);
    s_valid = 1'b0;
    wait_end();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sess == s) begin
        got = vecs[i].sel ? iram_mem[vecs[i].exp_addr] : dram_mem[vecs[i].exp_addr];
        check($sformatf("sess%0d_mem%0d", s, i), {16'd0, got}, {16'd0, vecs[i].data});
      end
    end
    check($sformatf("sess%0d_word_count", s), {22'd0, word_count}, exp_wc);
    check($sformatf("sess%0d_status", s), {28'd0, done, error, busy, s_ready}, 32'b1000);
    check($sformatf("sess%0d_start_len", s), n_ps - ps0, 2);
  endtask

  initial begin
    int ps0, dwe0;
    logic [7:0] we_pat, re_pat, ps_pat, rdy_pat, dn_pat;
    logic       stable;

    n_pass = 0; n_total = 0;
    corrupt = 1'b0;
    rst_n = 1'b0; load_req = 1'b0; s_valid = 1'b0; s_sel = 1'b0; s_last = 1'b0; s_data = '0;

    vecs[0] = '{0, 1'b0, 16'd5,   1'b0, 1};
    vecs[1] = '{0, 1'b0, 16'd7,   1'b0, 2};
    vecs[2] = '{0, 1'b0, 16'd9,   1'b0, 3};
    vecs[3] = '{0, 1'b1, 16'd100, 1'b0, 1};
    vecs[4] = '{0, 1'b1, 16'd101, 1'b1, 2};
    vecs[5] = '{1, 1'b1, 16'h71,  1'b0, 1};
    vecs[6] = '{1, 1'b0, 16'h72,  1'b0, 1};
    vecs[7] = '{1, 1'b1, 16'h73,  1'b0, 2};
    vecs[8] = '{1, 1'b0, 16'h74,  1'b0, 2};
    vecs[9] = '{1, 1'b1, 16'h75,  1'b1, 3};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {23'd0, s_ready, busy, done, error, proc_start, dram_we, iram_we, dram_re, iram_re}, 0);
    check("rst_mem_addr", {23'd0, mem_addr}, 0);
    check("rst_err_addr", {23'd0, err_addr}, 0);
    check("rst_word_count", {22'd0, word_count}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_session(0, 5);

    pulse_load();
    send(1'b0, 16'hABCD, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we_pat[7-i]  = dram_we;
      re_pat[7-i]  = dram_re;
      ps_pat[7-i]  = proc_start;
      rdy_pat[7-i] = s_ready;
      dn_pat[7-i]  = done;
      if (i < 5 && (mem_addr != 9'd1 || mem_wdata != 16'hABCD)) stable = 1'b0;
      @(negedge clk);
    end
    check("tim_we", {24'd0, we_pat}, 32'h40);
    check("tim_re", {24'd0, re_pat}, 32'h10);
    check("tim_start", {24'd0, ps_pat}, 32'h06);
    check("tim_ready", {24'd0, rdy_pat}, 32'h00);
    check("tim_done", {24'd0, dn_pat}, 32'h01);
    check("tim_stable", {31'd0, stable}, 1);
    check("tim_mem", {16'd0, dram_mem[1]}, 32'hABCD);

    corrupt = 1'b1;
    ps0 = n_ps;
    pulse_load();
    send(1'b0, 16'h11, 1'b0);
    send(1'b0, 16'h22, 1'b0);
    s_valid = 1'b0;
    wait_end();
    @(negedge clk);
    check("cor_status", {28'd0, done, error, busy, s_ready}, 32'b0100);
    check("cor_err_addr", {23'd0, err_addr}, 2);
    check("cor_word_count", {22'd0, word_count}, 1);
    check("cor_no_start", n_ps - ps0, 0);
    corrupt = 1'b0;

    ps0 = n_ps;
    dwe0 = n_dwe;
    pulse_load();
    send(1'b0, 16'h41, 1'b0);
    send(1'b0, 16'h42, 1'b0);
    send(1'b0, 16'h43, 1'b0);
    send(1'b0, 16'h44, 1'b0);
    s_valid = 1'b0;
    wait_end();
    @(negedge clk);
    check("ovf_error", {31'd0, error}, 1);
    check("ovf_err_addr", {23'd0, err_addr}, 4);
    check("ovf_we_count", n_dwe - dwe0, 3);
    check("ovf_word_count", {22'd0, word_count}, 3);
    check("ovf_mem", {dram_mem[1][7:0], dram_mem[2][7:0], dram_mem[3][7:0], 8'd0}, 32'h41424300);
    check("ovf_no_start", n_ps - ps0, 0);

    pulse_load();
    send(1'b0, 16'h55, 1'b1);
    @(posedge clk);
    #1;
    check("rstw_we_high", {31'd0, dram_we}, 1);
    rst_n = 1'b0;
    #1;
    check("rstw_we_drop", {31'd0, dram_we}, 0);
    check("rstw_outputs", {9'd0, s_ready, busy, done, error, proc_start, mem_addr, word_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_no_write", {16'd0, dram_mem[1]}, 32'h41);
    pulse_load();
    send(1'b0, 16'h66, 1'b1);
    s_valid = 1'b0;
    wait_end();
    @(negedge clk);
    check("rstw_rewrite", {16'd0, dram_mem[1]}, 32'h66);
    check("rstw_word_count", {22'd0, word_count}, 1);
    check("rstw_done", {30'd0, done, error}, 32'b10);

    run_session(1, 5);
    check("enable_overlap", n_ovl, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Synthesizable loader that moves a word stream into the processor's data memory (DRAM) and instruction memory (IRAM), then launches the processor with a start pulse.
- Replaces the bench-driven write sequencing with fixed setup/write/hold timing, so written data cannot be overwritten mid-write.
- Adds optional read-back verify.
- Sits between the host/UART stream source and the memory-write ports of top_layer.

Parameters:
DW, 16, data word width
AW, 9, memory address width
BASE_ADDR, 1, first address written in each memory
MAX_ADDR, 511, last legal address (inclusive, ≤ 2^AW-1)
VERIFY, 1, 1 = read back and compare every word; 0 = skip
RD_LAT, 1, memory read latency in cycles (1..4)
START_LEN, 2, proc_start pulse length in cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_req  in  1  one-cycle request to open a load session
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts word
s_data  in  DW  stream word
s_sel  in  1  target: 0 = DRAM, 1 = IRAM
s_last  in  1  final word of session
mem_addr  out  AW  shared memory address
mem_wdata  out  DW  shared write data
dram_we  out  1  DRAM write enable
iram_we  out  1  IRAM write enable
dram_re  out  1  DRAM read enable
iram_re  out  1  IRAM read enable
dram_rdata  in  DW  DRAM read data
iram_rdata  in  DW  IRAM read data
proc_start  out  1  processor start pulse
busy  out  1  session in progress
done  out  1  sticky: session finished cleanly
error  out  1  sticky: verify mismatch or address overflow
err_addr  out  AW  address of first error
word_count  out  AW+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; both address counters = BASE_ADDR. Reset mid-session abandons the session immediately; any write enable deasserts asynchronously.
- States: IDLE, ACCEPT, SETUP, WRITE, HOLD, RD, CMP, START, DONE, ERR.
- IDLE: s_ready=0. load_req -> clear done/error/err_addr/word_count, reset both counters to BASE_ADDR, go to ACCEPT. load_req in any other state is ignored.
- ACCEPT: s_ready=1, busy=1. On s_valid, latch s_data/s_sel/s_last and go to SETUP.
  - If the selected counter > MAX_ADDR: error=1, err_addr=counter, go to ERR with no write.
- Write timing per word:
  - SETUP (1 cycle): mem_addr/mem_wdata driven, no enable.
  - WRITE (1 cycle): the selected *_we=1.
  - HOLD (1 cycle): enables 0, addr/data still held.
  - Accepted word to write completion is 3 cycles.
- VERIFY=1:
  - RD: selected *_re=1 for 1 cycle, then wait RD_LAT cycles.
  - CMP: compare the selected rdata to the latched word.
  - Mismatch -> error=1, err_addr=mem_addr, go to ERR.
- After HOLD (VERIFY=0) or a passing CMP:
  - Increment the selected counter and word_count.
  - If the latched s_last=1, go to START; otherwise go to ACCEPT.
- Counters are independent: DRAM and IRAM words may interleave in any order.
- START: proc_start=1 for exactly START_LEN cycles, then DONE.
- DONE: done=1, busy=0, s_ready=0; the next load_req starts a new session.
- ERR: busy=0, s_ready=0, proc_start never asserted; only load_req or reset leaves ERR.
- The DRAM and IRAM write enables are never high in the same cycle. At most one of the four enables is high in any cycle.
- The s_last word is written and verified before START.

Decomposition:
- Package mem_loader_pkg: state enum, target encodings (SEL_DRAM=0, SEL_IRAM=1).
- One sub-module, loader_addr_ctr: a per-target counter with load, increment and overflow compare, instantiated twice.

Test Plan:
- VERIFY=1, RD_LAT=1: DRAM words 5,7,9 then IRAM 100,101(last) -> DRAM addr1..3 = 5,7,9; IRAM addr1..2 = 100,101; word_count=5; proc_start high 2 cycles; done=1.
- Timing check: one word 16'hABCD to DRAM -> dram_we high exactly one cycle, mem_addr/mem_wdata stable from SETUP through HOLD; s_ready low from accept until CMP complete.
- Memory model corrupts DRAM addr 2 -> error=1, err_addr=2, proc_start never asserted, busy=0.
- MAX_ADDR=3: four DRAM words -> first three written to addr1..3; fourth gives error=1, err_addr=4, dram_we not asserted for it.
- rst_n pulsed low during WRITE -> dram_we drops immediately; after release state is IDLE with all outputs 0; a new load_req writes from addr1 again.
- Sel alternates IRAM/DRAM with s_valid held high continuously -> each counter advances only on its own target's words; enables never overlap.
